// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the mem-stage LSU: access sizes, FSM states, fault causes.
package mem_stage_lsu_pkg;

    typedef enum logic [2:0] {
        RwB   = 3'b000,
        RwH   = 3'b001,
        RwW   = 3'b010,
        RwD   = 3'b011,
        RwBu  = 3'b100,
        RwHu  = 3'b101,
        RwWu  = 3'b110,
        RwRsv = 3'b111
    } rw_type_e;

    typedef enum logic [1:0] {
        LsuIdle,
        LsuReq,
        LsuWait,
        LsuDone
    } lsu_state_e;

    typedef enum logic [1:0] {
        ExcNone  = 2'b00,
        ExcMisal = 2'b01,
        ExcBus   = 2'b10,
        ExcTmo   = 2'b11
    } exc_cause_e;

    // size is RW_type[1:0]: 0 byte, 1 half, 2 word, 3 dword
    function automatic logic misaligned(logic [1:0] size, logic [2:0] offset);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return offset[0];
            2'b10:   return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// req/gnt/rvalid data bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational access checks, store lane steering and load extraction/extension.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic        is_read,
    input  logic        is_write,
    input  logic [2:0]  rw_type,
    input  logic [2:0]  offset,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic        fault,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_lanes,
    output logic [63:0] rdata_ext
);

    logic [1:0]  size;
    logic [7:0]  strb_base;
    logic [63:0] shifted;

    assign size    = rw_type[1:0];
    assign shifted = rdata >> {offset, 3'b000};

    // Unsigned variants are load-only; a store with them is illegal.
    assign fault = (rw_type == RwRsv) | (is_write & rw_type[2]) | (is_read & is_write) |
                   misaligned(size, offset);

    always_comb begin
        strb_base   = 8'h00;
        wdata_lanes = '0;
        case (size)
            2'b00: begin
                strb_base   = 8'h01;
                wdata_lanes = {8{wdata[7:0]}};
            end
            2'b01: begin
                strb_base   = 8'h03;
                wdata_lanes = {4{wdata[15:0]}};
            end
            2'b10: begin
                strb_base   = 8'h0F;
                wdata_lanes = {2{wdata[31:0]}};
            end
            default: begin
                strb_base   = 8'hFF;
                wdata_lanes = wdata;
            end
        endcase
        wstrb = strb_base << offset;
    end

    always_comb begin
        rdata_ext = '0;
        case (rw_type_e'(rw_type))
            RwB:     rdata_ext = {{56{shifted[7]}}, shifted[7:0]};
            RwH:     rdata_ext = {{48{shifted[15]}}, shifted[15:0]};
            RwW:     rdata_ext = {{32{shifted[31]}}, shifted[31:0]};
            RwD:     rdata_ext = shifted;
            RwBu:    rdata_ext = {56'd0, shifted[7:0]};
            RwHu:    rdata_ext = {48'd0, shifted[15:0]};
            RwWu:    rdata_ext = {32'd0, shifted[31:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Mem-stage load/store unit: one bus access per instruction, pipeline stalled until it retires.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memreadM,
    input  logic                  memwriteM,
    input  logic [2:0]            RW_typeM,
    input  logic [63:0]           addrM,
    input  logic [63:0]           wdataM,
    output logic                  stallM,
    output logic [63:0]           rdataM,
    output logic                  doneM,
    output logic                  excM,
    output logic [1:0]            exc_causeM,
    mem_stage_lsu_if.master       bus
);

    localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

    lsu_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [7:0]    wstrb_q, wstrb_d;
    logic          exc_q, exc_d;
    logic [1:0]    cause_q, cause_d;
    logic [63:0]   rdata_q, rdata_d;

    logic          acc;
    logic          fault;
    logic          tmo;
    logic [7:0]    wstrb_lanes;
    logic [63:0]   wdata_lanes;
    logic [63:0]   rdata_ext;

    mem_stage_lsu_align u_align (
        .is_read     (memreadM),
        .is_write    (memwriteM),
        .rw_type     (RW_typeM),
        .offset      (addrM[2:0]),
        .wdata       (wdataM),
        .rdata       (bus.bus_rdata),
        .fault       (fault),
        .wstrb       (wstrb_lanes),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    assign acc     = memreadM | memwriteM;
    assign cnt_inc = cnt_q + 1'b1;
    assign tmo     = (cnt_inc == CntW'(WAIT_MAX));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        exc_d      = exc_q;
        cause_d    = cause_q;
        rdata_d    = rdata_q;
        stallM     = 1'b0;
        doneM      = 1'b0;
        excM       = 1'b0;
        exc_causeM = ExcNone;
        rdataM     = '0;

        case (state_q)
            LsuIdle: begin
                if (acc && fault) begin
                    excM       = 1'b1;
                    exc_causeM = ExcMisal;
                end else if (acc) begin
                    stallM  = 1'b1;
                    state_d = LsuReq;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = memwriteM;
                    addr_d  = {addrM[63:3], 3'b000};
                    wdata_d = memwriteM ? wdata_lanes : '0;
                    wstrb_d = memwriteM ? wstrb_lanes : '0;
                    exc_d   = 1'b0;
                    cause_d = ExcNone;
                    rdata_d = '0;
                end
            end
            LsuReq: begin
                stallM = 1'b1;
                cnt_d  = cnt_inc;
                if (tmo) begin
                    state_d = LsuDone;
                    req_d   = 1'b0;
                    exc_d   = 1'b1;
                    cause_d = ExcTmo;
                end else if (bus.bus_gnt) begin
                    state_d = LsuWait;
                    req_d   = 1'b0;
                end
            end
            LsuWait: begin
                stallM = 1'b1;
                cnt_d  = cnt_inc;
                // A response in the same cycle as the deadline still counts.
                if (bus.bus_rvalid) begin
                    state_d = LsuDone;
                    if (bus.bus_err) begin
                        exc_d   = 1'b1;
                        cause_d = ExcBus;
                    end else if (!we_q) begin
                        rdata_d = rdata_ext;
                    end
                end else if (tmo) begin
                    state_d = LsuDone;
                    exc_d   = 1'b1;
                    cause_d = ExcTmo;
                end
            end
            LsuDone: begin
                doneM      = 1'b1;
                excM       = exc_q;
                exc_causeM = cause_q;
                rdataM     = rdata_q;
                state_d    = LsuIdle;
                we_d       = 1'b0;
                addr_d     = '0;
                wdata_d    = '0;
                wstrb_d    = '0;
            end
            default: state_d = LsuIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LsuIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            exc_q   <= 1'b0;
            cause_q <= ExcNone;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, faults, bus error, timeout and reset.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        memreadM;
    logic        memwriteM;
    logic [2:0]  RW_typeM;
    logic [63:0] addrM;
    logic [63:0] wdataM;
    logic        stallM;
    logic [63:0] rdataM;
    logic        doneM;
    logic        excM;
    logic [1:0]  exc_causeM;

    int n_checks = 0;
    int n_bad    = 0;

    typedef struct {
        int          stall;
        int          req_at;
        int          done_at;
        logic        done;
        logic [63:0] rdata;
        logic        exc;
        logic [1:0]  cause;
        logic [63:0] baddr;
        logic [63:0] bwdata;
        logic [7:0]  bstrb;
        logic        bwe;
    } res_t;

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(.WAIT_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .RW_typeM   (RW_typeM),
        .addrM      (addrM),
        .wdataM     (wdataM),
        .stallM     (stallM),
        .rdataM     (rdataM),
        .doneM      (doneM),
        .excM       (excM),
        .exc_causeM (exc_causeM),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one access from just after a rising edge; memory grants in the first REQ cycle
    // and answers one cycle later unless respond=0.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] rw,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rsp, input logic err, input logic respond,
                              output res_t res);
        logic granted;
        logic sent;
        res = '{stall: 0, req_at: -1, done_at: -1, done: 1'b0, rdata: '0, exc: 1'b0,
                cause: '0, baddr: '0, bwdata: '0, bstrb: '0, bwe: 1'b0};
        granted   = 1'b0;
        sent      = 1'b0;
        memreadM  = rd;
        memwriteM = wr;
        RW_typeM  = rw;
        addrM     = a;
        wdataM    = wd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (stallM) res.stall++;
            bus_if.bus_gnt    = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            bus_if.bus_err    = 1'b0;
            if (granted && respond && !sent) begin
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = rsp;
                bus_if.bus_err    = err;
                sent              = 1'b1;
            end
            if (bus_if.bus_req && !granted) begin
                res.req_at     = cyc;
                res.baddr      = bus_if.bus_addr;
                res.bwdata     = bus_if.bus_wdata;
                res.bstrb      = bus_if.bus_wstrb;
                res.bwe        = bus_if.bus_we;
                bus_if.bus_gnt = 1'b1;
                granted        = 1'b1;
            end
            if (doneM) begin
                res.done    = 1'b1;
                res.done_at = cyc;
                res.rdata   = rdataM;
                res.exc     = excM;
                res.cause   = exc_causeM;
                break;
            end
        end
        @(posedge clk);
        #1;
        memreadM          = 1'b0;
        memwriteM         = 1'b0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_err    = 1'b0;
    endtask

    task automatic fault_case(input string tag, input logic rd, input logic wr,
                              input logic [2:0] rw, input logic [63:0] a);
        memreadM  = rd;
        memwriteM = wr;
        RW_typeM  = rw;
        addrM     = a;
        wdataM    = 64'h1234;
        #1;
        check_eq({tag, "_exc"}, excM, 1'b1);
        check_eq({tag, "_cause"}, exc_causeM, 2'b01);
        check_eq({tag, "_stall"}, stallM, 1'b0);
        @(posedge clk);
        #1;
        check_eq({tag, "_noreq"}, bus_if.bus_req, 1'b0);
        memreadM  = 1'b0;
        memwriteM = 1'b0;
        @(posedge clk);
        #1;
    endtask

    res_t r;

    initial begin
        rst               = 1'b1;
        memreadM          = 1'b0;
        memwriteM         = 1'b0;
        RW_typeM          = 3'b000;
        addrM             = '0;
        wdataM            = '0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
        bus_if.bus_err    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", bus_if.bus_req, 1'b0);
        check_eq("rst_stall", stallM, 1'b0);
        check_eq("rst_done", doneM, 1'b0);
        check_eq("rst_exc", {excM, exc_causeM}, 3'b000);
        check_eq("rst_rdata", rdataM, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ld
        run_access(1, 0, 3'b011, 64'h1000, 0, 64'h1122334455667788, 0, 1, r);
        check_eq("ld_done", r.done, 1'b1);
        check_eq("ld_stall", r.stall, 3);
        check_eq("ld_rdata", r.rdata, 64'h1122334455667788);
        check_eq("ld_addr", r.baddr, 64'h1000);
        check_eq("ld_we", r.bwe, 1'b0);
        check_eq("ld_exc", r.exc, 1'b0);

        // lb / lbu, byte 3 = 0x80
        run_access(1, 0, 3'b000, 64'h1003, 0, 64'h0000000080000000, 0, 1, r);
        check_eq("lb_rdata", r.rdata, 64'hFFFFFFFFFFFFFF80);
        run_access(1, 0, 3'b100, 64'h1003, 0, 64'h0000000080000000, 0, 1, r);
        check_eq("lbu_rdata", r.rdata, 64'h0000000000000080);

        // lh / lw / lwu at offset 4
        run_access(1, 0, 3'b001, 64'h1004, 0, 64'h0123876543210000, 0, 1, r);
        check_eq("lh_rdata", r.rdata, 64'hFFFFFFFFFFFF8765);
        run_access(1, 0, 3'b010, 64'h1004, 0, 64'h8000000112345678, 0, 1, r);
        check_eq("lw_rdata", r.rdata, 64'hFFFFFFFF80000001);
        run_access(1, 0, 3'b110, 64'h1004, 0, 64'h8000000112345678, 0, 1, r);
        check_eq("lwu_rdata", r.rdata, 64'h0000000080000001);

        // sh
        run_access(0, 1, 3'b001, 64'h2006, 64'hBEEF, 64'hDEADDEADDEADDEAD, 0, 1, r);
        check_eq("sh_strb", r.bstrb, 8'hC0);
        check_eq("sh_wdata", r.bwdata, 64'hBEEFBEEFBEEFBEEF);
        check_eq("sh_addr", r.baddr, 64'h2000);
        check_eq("sh_we", r.bwe, 1'b1);
        check_eq("sh_rdata", r.rdata, 64'h0);
        check_eq("sh_done", r.done, 1'b1);

        // sb / sw
        run_access(0, 1, 3'b000, 64'h3005, 64'hFFA5, 0, 0, 1, r);
        check_eq("sb_strb", r.bstrb, 8'h20);
        check_eq("sb_wdata", r.bwdata, 64'hA5A5A5A5A5A5A5A5);
        run_access(0, 1, 3'b010, 64'h300C, 64'hCAFEF00D, 0, 0, 1, r);
        check_eq("sw_strb", r.bstrb, 8'hF0);
        check_eq("sw_wdata", r.bwdata, 64'hCAFEF00DCAFEF00D);
        check_eq("sw_addr", r.baddr, 64'h3008);

        // faults
        fault_case("lw_mis", 1, 0, 3'b010, 64'h1002);
        fault_case("ld_mis", 1, 0, 3'b011, 64'h1004);
        fault_case("rsv", 1, 0, 3'b111, 64'h1000);
        fault_case("sbu", 0, 1, 3'b100, 64'h1000);
        fault_case("rdwr", 1, 1, 3'b000, 64'h1000);

        // bus error
        run_access(1, 0, 3'b011, 64'h4000, 0, 64'h5555, 1, 1, r);
        check_eq("err_exc", r.exc, 1'b1);
        check_eq("err_cause", r.cause, 2'b10);
        check_eq("err_rdata", r.rdata, 64'h0);

        // timeout, then a late rvalid in IDLE
        run_access(1, 0, 3'b011, 64'h5000, 0, 0, 0, 0, r);
        check_eq("tmo_done", r.done, 1'b1);
        check_eq("tmo_latency", r.done_at - r.req_at, 8);
        check_eq("tmo_exc", r.exc, 1'b1);
        check_eq("tmo_cause", r.cause, 2'b11);
        check_eq("tmo_rdata", r.rdata, 64'h0);
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 64'h77;
        @(posedge clk);
        #1;
        bus_if.bus_rvalid = 1'b0;
        @(negedge clk);
        check_eq("late_rvalid", {stallM, doneM, excM, bus_if.bus_req}, 4'b0000);

        // reset during WAIT
        @(posedge clk);
        #1;
        memreadM = 1'b1;
        RW_typeM = 3'b011;
        addrM    = 64'h6000;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstw_req_up", bus_if.bus_req, 1'b1);
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        check_eq("rstw_in_wait", {stallM, bus_if.bus_req}, 2'b10);
        #2;
        rst      = 1'b1;
        memreadM = 1'b0;
        #1;
        check_eq("rstw_stall", {stallM, bus_if.bus_req}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rstw_idle", {stallM, doneM, bus_if.bus_req}, 3'b000);

        // reset during REQ drops bus_req without waiting for an edge
        memreadM = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstr_req_up", bus_if.bus_req, 1'b1);
        #1;
        rst      = 1'b1;
        memreadM = 1'b0;
        #1;
        check_eq("rstr_async", bus_if.bus_req, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // recovery: a normal load still works
        run_access(1, 0, 3'b011, 64'h7000, 0, 64'hA5A5000011112222, 0, 1, r);
        check_eq("post_rst_rdata", r.rdata, 64'hA5A5000011112222);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
